// File: rtl/mac_tile_vec.sv
// mac_tile_vec: systolic MAC tile with LANES signed multiplies per cycle.
// Weight-stationary mode passes psums north->south through a combinational MAC.
// Output-stationary mode accumulates locally and drains through out_s on request.
module mac_tile_vec #(
    parameter int BW      = 4,
    parameter int PSUM_BW = 16,
    parameter int LANES   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  os_en,
    input  logic [LANES*BW-1:0]   in_w,
    input  logic [2:0]            inst_w,
    input  logic [PSUM_BW-1:0]    in_n,
    output logic [LANES*BW-1:0]   out_e,
    output logic [2:0]            inst_e,
    output logic [PSUM_BW-1:0]    out_s,
    output logic [PSUM_BW-1:0]    c_q_out,
    output logic                  drain_valid,
    output logic                  sat_flag
);

    localparam int VW = LANES * BW;

    typedef enum logic [1:0] {IDLE, ACC, FOLD, DRAIN} state_e;

    state_e               state_q, state_d;
    logic                 mode_q, mode_d;
    logic                 loaded_q, loaded_d;
    logic [VW-1:0]        a_q, a_d;
    logic [VW-1:0]        b_q, b_d;
    logic [PSUM_BW-1:0]   c_q, c_d;
    logic [2:0]           inst_e_q, inst_e_d;
    logic                 drain_valid_q, drain_valid_d;
    logic                 sat_q, sat_d;

    logic signed [2*BW-1:0]    prod;
    logic signed [PSUM_BW-1:0] dot;
    logic signed [PSUM_BW:0]   mac_full;
    logic                      mac_ovf;
    logic [PSUM_BW-1:0]        mac_sat;

    // Dot product of the registered operands plus c_q, clamped to the psum range.
    always_comb begin
        dot = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            prod = $signed(a_q[k*BW +: BW]) * $signed(b_q[k*BW +: BW]);
            dot  = dot + $signed({{(PSUM_BW-2*BW){prod[2*BW-1]}}, prod});
        end
        mac_full = $signed({c_q[PSUM_BW-1], c_q}) + $signed({dot[PSUM_BW-1], dot});
        // One guard bit suffices: c_q and dot both fit in PSUM_BW signed bits.
        mac_ovf  = mac_full[PSUM_BW] ^ mac_full[PSUM_BW-1];
        mac_sat  = mac_ovf ? {mac_full[PSUM_BW], {(PSUM_BW-1){~mac_full[PSUM_BW]}}}
                           : mac_full[PSUM_BW-1:0];
    end

    // Next-state logic for both dataflow modes and the OS control FSM.
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        loaded_d      = loaded_q;
        a_d           = a_q;
        b_d           = b_q;
        c_d           = c_q;
        inst_e_d      = inst_e_q;
        drain_valid_d = 1'b0;
        sat_d         = sat_q;
        if (!mode_q) begin
            // WS never leaves IDLE, so the mode register follows os_en every cycle.
            mode_d   = os_en;
            c_d      = in_n;
            if (inst_w[0] || inst_w[1]) a_d = in_w;
            if (inst_w[0] && !loaded_q) begin
                b_d      = in_w;
                loaded_d = 1'b1;
            end
            inst_e_d = {1'b0, inst_w[1], inst_w[0] & loaded_q};
        end else begin
            loaded_d = 1'b1;
            inst_e_d = inst_w;
            if (inst_w[1]) begin
                a_d = in_w;
                b_d = in_n[VW-1:0];
            end
            unique case (state_q)
                IDLE: begin
                    // Mode only re-latches when idle is not being left this cycle.
                    if (inst_w[1]) begin
                        state_d = ACC;
                    end else if (inst_w[2]) begin
                        state_d       = DRAIN;
                        drain_valid_d = 1'b1;
                    end else begin
                        mode_d = os_en;
                    end
                end
                ACC: begin
                    if (inst_w[1]) begin
                        c_d   = mac_sat;
                        sat_d = sat_q | mac_ovf;
                    end else begin
                        state_d = FOLD;
                    end
                end
                FOLD: begin
                    c_d     = mac_sat;
                    sat_d   = sat_q | mac_ovf;
                    state_d = IDLE;
                end
                DRAIN: begin
                    c_d     = '0;
                    sat_d   = 1'b0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            mode_q        <= 1'b0;
            loaded_q      <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            c_q           <= '0;
            inst_e_q      <= '0;
            drain_valid_q <= 1'b0;
            sat_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            loaded_q      <= loaded_d;
            a_q           <= a_d;
            b_q           <= b_d;
            c_q           <= c_d;
            inst_e_q      <= inst_e_d;
            drain_valid_q <= drain_valid_d;
            sat_q         <= sat_d;
        end
    end

    // South output: WS psum, OS weight pass-through, or the local accumulator.
    always_comb begin
        if (!mode_q)                out_s = mac_sat;
        else if (state_q == DRAIN)  out_s = c_q;
        else if (inst_w[1])         out_s = {{(PSUM_BW-VW){1'b0}}, in_n[VW-1:0]};
        else                        out_s = c_q;
    end

    assign out_e       = a_q;
    assign inst_e      = inst_e_q;
    assign c_q_out     = c_q;
    assign drain_valid = drain_valid_q;
    assign sat_flag    = sat_q;

endmodule

// File: tb/tb_mac_tile_vec.sv
// Directed self-checking bench for mac_tile_vec at default parameters.
module tb_mac_tile_vec;

    logic        clk;
    logic        reset;
    logic        os_en;
    logic [7:0]  in_w;
    logic [2:0]  inst_w;
    logic [15:0] in_n;
    logic [7:0]  out_e;
    logic [2:0]  inst_e;
    logic [15:0] out_s;
    logic [15:0] c_q_out;
    logic        drain_valid;
    logic        sat_flag;

    int errors = 0;
    int checks = 0;

    mac_tile_vec #(.BW(4), .PSUM_BW(16), .LANES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .os_en       (os_en),
        .in_w        (in_w),
        .inst_w      (inst_w),
        .in_n        (in_n),
        .out_e       (out_e),
        .inst_e      (inst_e),
        .out_s       (out_s),
        .c_q_out     (c_q_out),
        .drain_valid (drain_valid),
        .sat_flag    (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out_e"},  {24'h0, out_e},        32'h0);
        chk({tag, "_inst_e"}, {29'h0, inst_e},       32'h0);
        chk({tag, "_out_s"},  {16'h0, out_s},        32'h0);
        chk({tag, "_c_q"},    {16'h0, c_q_out},      32'h0);
        chk({tag, "_dv"},     {31'h0, drain_valid},  32'h0);
        chk({tag, "_sat"},    {31'h0, sat_flag},     32'h0);
    endtask

    initial begin
        reset = 1'b1; os_en = 1'b0; in_w = '0; inst_w = '0; in_n = '0;
        #2 reset = 1'b0;
        #1 chk_all_zero("reset");
        tick();
        reset = 1'b1;

        // WS first load: b = {2,-3}; the load is consumed, not forwarded
        in_w = 8'h2D; inst_w = 3'b001; in_n = 16'h0;
        tick();
        chk("ws_load_out_e",  {24'h0, out_e},  32'h2D);
        chk("ws_load_inst_e", {29'h0, inst_e}, 32'h0);

        // WS execute: a = {3,1}, in_n = 10 -> 10 + 6 - 3 = 13
        in_w = 8'h31; inst_w = 3'b010; in_n = 16'd10;
        tick();
        chk("ws_exec_c_q",    {16'h0, c_q_out}, 32'd10);
        chk("ws_exec_out_s",  {16'h0, out_s},   32'd13);
        chk("ws_exec_inst_e", {29'h0, inst_e},  32'h2);

        // Second load {5,5}: b stays {2,-3} -> 10 - 15 = -5
        in_w = 8'h55; inst_w = 3'b001; in_n = 16'h0;
        tick();
        chk("ws_reload_out_s",  {16'h0, out_s},  32'hFFFB);
        chk("ws_reload_inst_e", {29'h0, inst_e}, 32'h1);

        // WS positive clamp: 32767 + (7*2 + -8*-3) -> 32767, not sticky
        in_w = 8'h78; inst_w = 3'b010; in_n = 16'h7FFF;
        tick();
        chk("ws_clamp_out_s", {16'h0, out_s},    32'h7FFF);
        chk("ws_clamp_sat",   {31'h0, sat_flag}, 32'h0);

        // WS drain bit is not forwarded and does not capture activations
        in_w = 8'hFF; inst_w = 3'b100; in_n = 16'h8000;
        tick();
        chk("ws_drain_inst_e", {29'h0, inst_e}, 32'h0);
        chk("ws_hold_out_e",   {24'h0, out_e},  32'h78);
        chk("ws_neg_out_s",    {16'h0, out_s},  32'h8026);

        // Switch to OS while idle
        os_en = 1'b1; in_w = 8'h0; inst_w = 3'b000; in_n = 16'h0;
        tick();
        chk("os_start_c_q", {16'h0, c_q_out}, 32'h0);

        // OS: three executes with a = {1,1}, weights = {2,2}
        in_w = 8'h11; inst_w = 3'b010; in_n = 16'h0022;
        #1 chk("os_weight_pass", {16'h0, out_s}, 32'h0022);
        tick();
        chk("os_first_no_acc", {16'h0, c_q_out}, 32'h0);
        tick();
        tick();
        chk("os_inst_e_fwd", {29'h0, inst_e}, 32'h2);
        inst_w = 3'b000;
        tick();
        chk("os_to_fold_c_q", {16'h0, c_q_out}, 32'd8);
        tick();
        chk("os_fold_c_q", {16'h0, c_q_out}, 32'd12);

        // Drain
        inst_w = 3'b100;
        tick();
        chk("os_drain_dv",     {31'h0, drain_valid}, 32'h1);
        chk("os_drain_out_s",  {16'h0, out_s},       32'd12);
        chk("os_drain_inst_e", {29'h0, inst_e},      32'h4);
        inst_w = 3'b000;
        tick();
        chk("os_post_drain_dv",  {31'h0, drain_valid}, 32'h0);
        chk("os_post_drain_c_q", {16'h0, c_q_out},     32'h0);

        // Load in OS only forwards
        inst_w = 3'b001;
        tick();
        chk("os_load_inst_e", {29'h0, inst_e},  32'h1);
        chk("os_load_out_e",  {24'h0, out_e},   32'h11);
        chk("os_load_c_q",    {16'h0, c_q_out}, 32'h0);

        // Execute and drain together: execute wins
        in_w = 8'h11; inst_w = 3'b110; in_n = 16'h0022;
        tick();
        chk("exdr_dv", {31'h0, drain_valid}, 32'h0);
        inst_w = 3'b000;
        tick();
        chk("exdr_dv2", {31'h0, drain_valid}, 32'h0);
        tick();
        chk("exdr_fold_c_q", {16'h0, c_q_out}, 32'd4);

        // Saturation: 260 executes of (-8*-8)*2
        in_w = 8'h88; inst_w = 3'b010; in_n = 16'h0088;
        repeat (260) tick();
        chk("sat_c_q",  {16'h0, c_q_out}, 32'h7FFF);
        chk("sat_flag", {31'h0, sat_flag}, 32'h1);
        inst_w = 3'b000;
        tick();
        tick();
        chk("sat_fold_c_q",  {16'h0, c_q_out}, 32'h7FFF);
        chk("sat_fold_flag", {31'h0, sat_flag}, 32'h1);
        inst_w = 3'b100;
        tick();
        chk("sat_drain_out_s", {16'h0, out_s},    32'h7FFF);
        chk("sat_drain_flag",  {31'h0, sat_flag}, 32'h1);
        inst_w = 3'b000;
        tick();
        chk("sat_cleared", {31'h0, sat_flag}, 32'h0);
        chk("sat_c_q_clr", {16'h0, c_q_out},  32'h0);

        // os_en dropped mid-accumulation is ignored until idle
        in_w = 8'h11; inst_w = 3'b010; in_n = 16'h0022;
        tick();
        os_en = 1'b0;
        tick();
        tick();
        inst_w = 3'b000;
        tick();
        chk("tog_acc_c_q", {16'h0, c_q_out}, 32'd8);
        tick();
        chk("tog_fold_c_q", {16'h0, c_q_out}, 32'd12);
        in_n = 16'd5;
        #1 chk("tog_idle_os_out_s", {16'h0, out_s}, 32'd12);
        tick();
        chk("tog_ws_out_s", {16'h0, out_s}, 32'd16);
        tick();
        chk("tog_ws_c_q",   {16'h0, c_q_out}, 32'd5);
        chk("tog_ws_out_s2", {16'h0, out_s},  32'd9);

        // Reset mid-ACC with no clock edge
        os_en = 1'b1; inst_w = 3'b000;
        tick();
        in_w = 8'h11; inst_w = 3'b010; in_n = 16'h0022;
        tick();
        tick();
        chk("pre_rst_c_q", {16'h0, c_q_out}, 32'd9);
        #2 reset = 1'b0;
        #1 chk_all_zero("midacc_rst");
        inst_w = 3'b000; in_n = 16'h0;
        tick();
        reset = 1'b1;
        tick();
        inst_w = 3'b100;
        tick();
        chk("rst_drain_dv",    {31'h0, drain_valid}, 32'h1);
        chk("rst_drain_out_s", {16'h0, out_s},       32'h0);
        inst_w = 3'b000;
        tick();
        chk("rst_drain_dv_off", {31'h0, drain_valid}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
